// File: rtl/reg_pipe_ctrl_pkg.sv
// Shared types for the reg_pipe_ctrl valid/ready pipeline controller.
// Classifies each cycle's handshakes into an occupancy counter update.
package reg_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        OCC_HOLD = 2'd0,
        OCC_INC  = 2'd1,
        OCC_DEC  = 2'd2
    } occ_op_e;

    // An accepted beat and a delivered beat in the same cycle cancel out.
    function automatic occ_op_e occ_op(input logic s_fire, input logic m_fire);
        occ_op_e op;
        case ({s_fire, m_fire})
            2'b10:   op = OCC_INC;
            2'b01:   op = OCC_DEC;
            default: op = OCC_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_pipe_ctrl_chk.sv
// Property checker for reg_pipe_ctrl port behaviour; instantiated alongside the controller.
module reg_pipe_ctrl_chk #(
    parameter  int STAGES = 4,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input logic              clock,
    input logic              resetn,
    input logic              flush,
    input logic              s_ready,
    input logic              m_valid,
    input logic [STAGES-1:0] stage_en,
    input logic [STAGES-1:0] stage_valid,
    input logic [OCC_W-1:0]  occupancy
);

    a_occ_bound: assert property (@(posedge clock) disable iff (!resetn)
        occupancy <= OCC_W'(STAGES))
        else $error("FAIL occ_bound occupancy=%0d", occupancy);

    a_occ_matches_valid: assert property (@(posedge clock) disable iff (!resetn)
        $countones(stage_valid) == int'(occupancy))
        else $error("FAIL occ_vs_valid occupancy=%0d valid=%b", occupancy, stage_valid);

    a_sready_is_en0: assert property (@(posedge clock) disable iff (!resetn)
        s_ready == stage_en[0])
        else $error("FAIL sready_en0 s_ready=%b en=%b", s_ready, stage_en);

    a_flush_quiet: assert property (@(posedge clock) disable iff (!resetn)
        flush |-> (!m_valid && stage_en == {STAGES{1'b0}}))
        else $error("FAIL flush_quiet m_valid=%b en=%b", m_valid, stage_en);

endmodule

// File: rtl/reg_pipe_ctrl_valid_stage.sv
// One stage valid flop: async active-low reset, clock enable, sync flush.
module reg_pipe_ctrl_valid_stage (
    input  logic clock,
    input  logic resetn,
    input  logic flush,
    input  logic en,
    input  logic d,
    output logic q
);

    // Valid bit register; flush clears regardless of enable.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= 1'b0;
        end else if (flush) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/reg_pipe_ctrl.sv
// Valid/ready sequencer for a STAGES-deep datapath: per-stage enables, valid bits, occupancy.
// Build option: REG_PIPE_CTRL_COLLAPSE_EN selects bubble-collapsing enables instead of a global stall.
module reg_pipe_ctrl
    import reg_pipe_ctrl_pkg::*;
#(
    parameter  int STAGES = 4,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic              busy
);

    logic [STAGES-1:0] v_s;
    logic [STAGES-1:0] v_in_s;
    logic [STAGES-1:0] en_raw_s;
    logic              s_fire_s;
    logic              m_fire_s;
    logic [OCC_W-1:0]  occ_r;

    assign v_in_s[0] = s_valid;
    for (genvar i = 1; i < STAGES; i++) begin : g_vin
        assign v_in_s[i] = v_s[i-1];
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        reg_pipe_ctrl_valid_stage u_valid (
            .clock  (clock),
            .resetn (resetn),
            .flush  (flush),
            .en     (stage_en[i]),
            .d      (v_in_s[i]),
            .q      (v_s[i])
        );
    end

    // Enable chain: a stage may load when it, or everything downstream of it, can move.
    always_comb begin
        en_raw_s = {STAGES{1'b0}};
`ifdef REG_PIPE_CTRL_COLLAPSE_EN
        for (int i = 0; i < STAGES; i++) begin
            logic tail_full_s;
            // Unrolled form of en[i] = ~v[i] | en[i+1], avoiding a self-referencing vector.
            tail_full_s = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                tail_full_s = tail_full_s & v_s[j];
            end
            en_raw_s[i] = ~tail_full_s | m_ready;
        end
`else
        en_raw_s = {STAGES{~v_s[STAGES-1] | m_ready}};
`endif
        if (flush) begin
            stage_en = {STAGES{1'b0}};
        end else begin
            stage_en = en_raw_s;
        end
    end

    assign s_ready     = stage_en[0];
    assign m_valid     = v_s[STAGES-1] & ~flush;
    assign s_fire_s    = s_valid & s_ready;
    assign m_fire_s    = m_valid & m_ready;
    assign stage_valid = v_s;
    assign busy        = |v_s;
    assign occupancy   = occ_r;

    // Occupancy counter tracks accepted minus delivered beats.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (flush) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            case (occ_op(s_fire_s, m_fire_s))
                OCC_INC: occ_r <= occ_r + OCC_W'(1);
                OCC_DEC: occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_pipe_ctrl.sv
// Scoreboard bench for reg_pipe_ctrl: directed scenarios followed by random traffic.
module tb_reg_pipe_ctrl;

    localparam int STAGES = 4;
    localparam int OCC_W  = $clog2(STAGES + 1);

    logic              clock;
    logic              resetn;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic [OCC_W-1:0]  occupancy;
    logic              busy;
    logic [15:0]       s_data;
    logic [15:0]       dreg [STAGES];

    typedef struct {
        logic [15:0] data;
        int          t_in;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    strict_lat = 1'b0;
    int    m_count  = 0;
    int    m_first  = -1;
    int    m_last   = -1;
    int    occ_peak = 0;

    reg_pipe_ctrl #(.STAGES(STAGES)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .occupancy   (occupancy),
        .busy        (busy)
    );

    reg_pipe_ctrl_chk #(.STAGES(STAGES)) u_chk (
        .clock       (clock),
        .resetn      (resetn),
        .flush       (flush),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Datapath registers driven only by the controller's enables.
    always @(posedge clock) begin
        for (int i = 0; i < STAGES; i++) begin
            if (stage_en[i]) dreg[i] <= (i == 0) ? s_data : dreg[i-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compares against the in-flight beat queue and retires beats on m_fire.
    always @(negedge clock) begin
        if (!resetn) begin
            q.delete();
        end else begin
            beat_t b;
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("valid_count", 32'($countones(stage_valid)), 32'(q.size()));
            chk("m_valid_without_beat", 32'(m_valid && q.size() == 0), 32'd0);
            if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
            if (flush) begin
                chk("flush_s_ready", 32'(s_ready), 32'd0);
                chk("flush_m_valid", 32'(m_valid), 32'd0);
            end else begin
`ifdef REG_PIPE_CTRL_COLLAPSE_EN
                chk("s_ready_rule", 32'(s_ready), 32'(m_ready || q.size() < STAGES));
`else
                chk("s_ready_rule", 32'(s_ready), 32'(m_ready || !m_valid));
`endif
            end
            if (m_valid && m_ready && q.size() != 0) begin
                b = q.pop_front();
                chk("beat_data", 32'(dreg[STAGES-1]), 32'(b.data));
                if (strict_lat) chk("latency_exact", 32'(cyc - b.t_in), 32'(STAGES));
                else            chk("latency_min", 32'(cyc - b.t_in >= STAGES), 32'd1);
                m_count++;
                if (m_first < 0) m_first = cyc;
                m_last = cyc;
            end
            if (s_valid && s_ready) begin
                b.data = s_data;
                b.t_in = cyc;
                q.push_back(b);
            end
            if (flush) q.delete();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int n);
        int   sent  = 0;
        int   guard = 0;
        logic fired;
        if (!s_valid) s_data = 16'($urandom);
        s_valid = (n > 0);
        while (sent < n && guard < 200) begin
            #1;
            fired = s_ready;
            step();
            guard++;
            if (fired) begin
                sent++;
                s_data = 16'($urandom);
            end
        end
        s_valid = 1'b0;
        chk("send_timeout", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int guard = 0;
        m_ready = 1'b1;
        while (q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        step();
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int   sent;
        logic fired;
        logic hold;
        resetn  = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 16'd0;
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_stage_en", 32'(stage_en), 32'hF);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        step();

        // 1: back-to-back stream, exact latency, full throughput
        m_ready = 1'b1; strict_lat = 1'b1;
        m_count = 0; m_first = -1; m_last = -1; occ_peak = 0;
        send(8);
        repeat (6) step();
        chk("t1_m_count", 32'(m_count), 32'd8);
        chk("t1_consecutive", 32'(m_last - m_first), 32'd7);
        chk("t1_occ_peak", 32'(occ_peak), 32'd4);
        strict_lat = 1'b0;

        // 2: fill with downstream stalled, hold, then drain in order
        m_ready = 1'b0;
        send(4);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t2_s_ready", 32'(s_ready), 32'd0);
            chk("t2_stage_en", 32'(stage_en), 32'd0);
            chk("t2_occupancy", 32'(occupancy), 32'd4);
            step();
        end
        drain();

        // 3: beats on alternate cycles while stalled; source holds an unaccepted beat
        m_ready = 1'b0; sent = 0;
        for (int k = 0; k < 12; k++) begin
            if (!s_valid && sent < 4 && (k % 2) == 0) begin
                s_valid = 1'b1;
                s_data  = 16'($urandom);
            end
            #1;
            fired = s_valid && s_ready;
            step();
            if (fired) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        #1;
`ifdef REG_PIPE_CTRL_COLLAPSE_EN
        chk("t3_stage_valid", 32'(stage_valid), 32'hF);
        chk("t3_sent", 32'(sent), 32'd4);
`else
        // First two beats reach stages 3 and 1 before the global stall freezes everything.
        chk("t3_stage_valid", 32'(stage_valid), 32'hA);
        chk("t3_sent", 32'(sent), 32'd2);
`endif
        chk("t3_stage_en", 32'(stage_en), 32'd0);
        chk("t3_s_ready", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        send(4 - sent);
        drain();

        // 4: simultaneous accept and deliver at occupancy 2
        m_ready = 1'b0;
        send(2);
        repeat (4) step();
        chk("t4_occ_before", 32'(occupancy), 32'd2);
        s_valid = 1'b1; m_ready = 1'b1; s_data = 16'($urandom);
        #1;
        chk("t4_both_fire", 32'(s_ready && m_valid), 32'd1);
        step();
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("t4_occ_after", 32'(occupancy), 32'd2);
        step();
        drain();

        // 5: flush beats a pending accept and deliver
        m_ready = 1'b0;
        send(3);
        repeat (3) step();
        chk("t5_occ_before", 32'(occupancy), 32'd3);
        flush = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_stage_en", 32'(stage_en), 32'd0);
        step();
        flush = 1'b0; s_valid = 1'b0;
        #1;
        chk("t5_stage_valid", 32'(stage_valid), 32'd0);
        chk("t5_occupancy", 32'(occupancy), 32'd0);
        chk("t5_s_ready_after", 32'(s_ready), 32'd1);
        step();

        // 6: asynchronous reset mid-stream, then exact latency after release
        m_ready = 1'b1;
        send(6);
        #1 resetn = 1'b0;
        #1;
        chk("t6_m_valid", 32'(m_valid), 32'd0);
        chk("t6_occupancy", 32'(occupancy), 32'd0);
        chk("t6_stage_en", 32'(stage_en), 32'hF);
        step();
        resetn = 1'b1;
        step();
        strict_lat = 1'b1; m_count = 0;
        send(1);
        repeat (STAGES + 2) step();
        chk("t6_post_reset_beat", 32'(m_count), 32'd1);
        strict_lat = 1'b0;

        // Random traffic with occasional flush; source obeys hold-until-accepted.
        hold = 1'b0;
        for (int k = 0; k < 600; k++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            if (!hold) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 16'($urandom);
            end
            #1;
            hold = s_valid && !s_ready;
            step();
        end
        flush = 1'b0; s_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
